axi_lite_arbiter_2x1: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 10 +
 rtl/axi_lite_if.sv | 34 +++
 rtl/rr_arb2.sv | 12 +
 rtl/axi_lite_arbiter_2x1.sv | 189 ++++++++++++++++++
 tb/tb_axi_lite_arbiter_2x1.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite arbiter slice.
package axi_lite_pkg;

  typedef enum logic [1:0] {WR_IDLE, WR_FWD, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle. A transfer on any channel happens on a rising edge where valid
// and ready are both high; valid, once raised, holds with stable payload until then.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   aw_addr;
  logic                aw_valid;
  logic                aw_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_valid;
  logic                w_ready;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;
  logic [ADDR_W-1:0]   ar_addr;
  logic                ar_valid;
  logic                ar_ready;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);
  always_comb begin
    gnt = 1'b0;
    if (req == 2'b11) gnt = ~last;
    else if (req[1])  gnt = 1'b1;
  end
endmodule

// File: rtl/axi_lite_arbiter_2x1.sv
// Shares one AXI-Lite slave between two masters; write and read paths are arbitrated
// independently, each with a single outstanding transaction.
module axi_lite_arbiter_2x1
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  axi_lite_if.slave  up0,
  axi_lite_if.slave  up1,
  axi_lite_if.master dn,
  output wr_state_t wr_state_o,
  output rd_state_t rd_state_o
);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic wgnt_q, wgnt_d, wlast_q, wlast_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rgnt_q, rgnt_d, rlast_q, rlast_d;
  logic wr_arb_gnt, rd_arb_gnt;

  logic [ADDR_W-1:0]   sel_aw_addr, sel_ar_addr;
  logic [DATA_W-1:0]   sel_w_data;
  logic [DATA_W/8-1:0] sel_w_strb;
  logic sel_aw_valid, sel_w_valid, sel_b_ready, sel_ar_valid, sel_r_ready;
  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;

  rr_arb2 u_wr_arb (.req({up1.aw_valid, up0.aw_valid}), .last(wlast_q), .gnt(wr_arb_gnt));
  rr_arb2 u_rd_arb (.req({up1.ar_valid, up0.ar_valid}), .last(rlast_q), .gnt(rd_arb_gnt));

  always_comb begin
    sel_aw_addr  = wgnt_q ? up1.aw_addr  : up0.aw_addr;
    sel_aw_valid = wgnt_q ? up1.aw_valid : up0.aw_valid;
    sel_w_data   = wgnt_q ? up1.w_data   : up0.w_data;
    sel_w_strb   = wgnt_q ? up1.w_strb   : up0.w_strb;
    sel_w_valid  = wgnt_q ? up1.w_valid  : up0.w_valid;
    sel_b_ready  = wgnt_q ? up1.b_ready  : up0.b_ready;
    sel_ar_addr  = rgnt_q ? up1.ar_addr  : up0.ar_addr;
    sel_ar_valid = rgnt_q ? up1.ar_valid : up0.ar_valid;
    sel_r_ready  = rgnt_q ? up1.r_ready  : up0.r_ready;
  end

  // AW and W are masked independently once accepted, so either may finish first.
  assign aw_fire = (wr_state_q == WR_FWD) && sel_aw_valid && !aw_done_q && dn.aw_ready;
  assign w_fire  = (wr_state_q == WR_FWD) && sel_w_valid && !w_done_q && dn.w_ready;
  assign b_fire  = (wr_state_q == WR_RESP) && dn.b_valid && sel_b_ready;
  assign ar_fire = (rd_state_q == RD_ADDR) && sel_ar_valid && dn.ar_ready;
  assign r_fire  = (rd_state_q == RD_DATA) && dn.r_valid && sel_r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      wgnt_q     <= 1'b0;
      wlast_q    <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rd_state_q <= RD_IDLE;
      rgnt_q     <= 1'b0;
      rlast_q    <= 1'b1;
    end else begin
      wr_state_q <= wr_state_d;
      wgnt_q     <= wgnt_d;
      wlast_q    <= wlast_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rd_state_q <= rd_state_d;
      rgnt_q     <= rgnt_d;
      rlast_q    <= rlast_d;
    end
  end

  always_comb begin
    wr_state_d   = wr_state_q;
    wgnt_d       = wgnt_q;
    wlast_d      = wlast_q;
    aw_done_d    = aw_done_q | aw_fire;
    w_done_d     = w_done_q | w_fire;
    dn.aw_addr   = '0;
    dn.aw_valid  = 1'b0;
    dn.w_data    = '0;
    dn.w_strb    = '0;
    dn.w_valid   = 1'b0;
    dn.b_ready   = 1'b0;
    up0.aw_ready = 1'b0;
    up0.w_ready  = 1'b0;
    up0.b_resp   = 2'b00;
    up0.b_valid  = 1'b0;
    up1.aw_ready = 1'b0;
    up1.w_ready  = 1'b0;
    up1.b_resp   = 2'b00;
    up1.b_valid  = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (up0.aw_valid || up1.aw_valid) begin
          wgnt_d     = wr_arb_gnt;
          wr_state_d = WR_FWD;
        end
      end
      WR_FWD: begin
        dn.aw_addr  = sel_aw_addr;
        dn.aw_valid = sel_aw_valid & ~aw_done_q;
        dn.w_data   = sel_w_data;
        dn.w_strb   = sel_w_strb;
        dn.w_valid  = sel_w_valid & ~w_done_q;
        if (wgnt_q) begin
          up1.aw_ready = dn.aw_ready & ~aw_done_q;
          up1.w_ready  = dn.w_ready & ~w_done_q;
        end else begin
          up0.aw_ready = dn.aw_ready & ~aw_done_q;
          up0.w_ready  = dn.w_ready & ~w_done_q;
        end
        if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        dn.b_ready = sel_b_ready;
        if (wgnt_q) begin
          up1.b_resp  = dn.b_resp;
          up1.b_valid = dn.b_valid;
        end else begin
          up0.b_resp  = dn.b_resp;
          up0.b_valid = dn.b_valid;
        end
        if (b_fire) begin
          wlast_d    = wgnt_q;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d   = rd_state_q;
    rgnt_d       = rgnt_q;
    rlast_d      = rlast_q;
    dn.ar_addr   = '0;
    dn.ar_valid  = 1'b0;
    dn.r_ready   = 1'b0;
    up0.ar_ready = 1'b0;
    up0.r_data   = '0;
    up0.r_resp   = 2'b00;
    up0.r_valid  = 1'b0;
    up1.ar_ready = 1'b0;
    up1.r_data   = '0;
    up1.r_resp   = 2'b00;
    up1.r_valid  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (up0.ar_valid || up1.ar_valid) begin
          rgnt_d     = rd_arb_gnt;
          rd_state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        dn.ar_addr  = sel_ar_addr;
        dn.ar_valid = sel_ar_valid;
        if (rgnt_q) up1.ar_ready = dn.ar_ready;
        else        up0.ar_ready = dn.ar_ready;
        if (ar_fire) rd_state_d = RD_DATA;
      end
      RD_DATA: begin
        dn.r_ready = sel_r_ready;
        if (rgnt_q) begin
          up1.r_data  = dn.r_data;
          up1.r_resp  = dn.r_resp;
          up1.r_valid = dn.r_valid;
        end else begin
          up0.r_data  = dn.r_data;
          up0.r_resp  = dn.r_resp;
          up0.r_valid = dn.r_valid;
        end
        if (r_fire) begin
          rlast_d    = rgnt_q;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign wr_state_o = wr_state_q;
  assign rd_state_o = rd_state_q;

endmodule

// File: tb/tb_axi_lite_arbiter_2x1.sv
// Directed bench for axi_lite_arbiter_2x1: routing, round-robin order, W/AW ordering,
// read/write concurrency and mid-transaction reset.
module tb_axi_lite_arbiter_2x1;
  import axi_lite_pkg::*;

  logic clk = 1'b0;
  logic rst;
  wr_state_t wr_state;
  rd_state_t rd_state;
  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) up0_if ();
  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) up1_if ();
  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) dn_if ();

  axi_lite_arbiter_2x1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .up0        (up0_if),
    .up1        (up1_if),
    .dn         (dn_if),
    .wr_state_o (wr_state),
    .rd_state_o (rd_state)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  function automatic logic up1_any();
    return up1_if.aw_ready | up1_if.w_ready | up1_if.b_valid | up1_if.ar_ready | up1_if.r_valid;
  endfunction

  function automatic logic any_out();
    return up0_if.aw_ready | up0_if.w_ready | up0_if.b_valid | up0_if.ar_ready | up0_if.r_valid
         | up1_any()
         | dn_if.aw_valid | dn_if.w_valid | dn_if.b_ready | dn_if.ar_valid | dn_if.r_ready;
  endfunction

  task automatic clear_inputs;
    up0_if.aw_addr = '0; up0_if.aw_valid = 0; up0_if.w_data = '0; up0_if.w_strb = '0;
    up0_if.w_valid = 0;  up0_if.b_ready = 0;  up0_if.ar_addr = '0; up0_if.ar_valid = 0;
    up0_if.r_ready = 0;
    up1_if.aw_addr = '0; up1_if.aw_valid = 0; up1_if.w_data = '0; up1_if.w_strb = '0;
    up1_if.w_valid = 0;  up1_if.b_ready = 0;  up1_if.ar_addr = '0; up1_if.ar_valid = 0;
    up1_if.r_ready = 0;
    dn_if.aw_ready = 0; dn_if.w_ready = 0; dn_if.b_resp = '0; dn_if.b_valid = 0;
    dn_if.ar_ready = 0; dn_if.r_data = '0; dn_if.r_resp = '0; dn_if.r_valid = 0;
  endtask

  // Fairness traffic: master g's n-th write, or idle once six have been issued.
  task automatic load_wr(input int g, input int n);
    logic [31:0] a;
    logic [31:0] d;
    a = (g == 0 ? 32'h100 : 32'h200) + 32'(4 * n);
    d = (g == 0 ? 32'h0A00_0000 : 32'h0B00_0000) + 32'(n);
    if (g == 0) begin
      up0_if.aw_valid = (n < 6); up0_if.w_valid = (n < 6);
      up0_if.aw_addr = a; up0_if.w_data = d; up0_if.w_strb = 4'hF;
    end else begin
      up1_if.aw_valid = (n < 6); up1_if.w_valid = (n < 6);
      up1_if.aw_addr = a; up1_if.w_data = d; up1_if.w_strb = 4'hF;
    end
  endtask

  initial begin
    int cnt[2];
    int g;
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    // reset state
    chk1("rst_outs", any_out(), 1'b0);
    chk("rst_wr_state", 32'(wr_state), 32'(WR_IDLE));
    chk("rst_rd_state", 32'(rd_state), 32'(RD_IDLE));
    rst = 1'b0;

    // single write from up0
    up0_if.aw_addr = 32'h10; up0_if.aw_valid = 1;
    up0_if.w_data = 32'hDEAD_BEEF; up0_if.w_strb = 4'hF; up0_if.w_valid = 1;
    dn_if.aw_ready = 1; dn_if.w_ready = 1;
    settle();
    chk1("sw_idle_no_fwd", dn_if.aw_valid, 1'b0);
    tick();
    chk1("sw_aw_valid", dn_if.aw_valid, 1'b1);
    chk("sw_aw_addr", dn_if.aw_addr, 32'h10);
    chk("sw_w_data", dn_if.w_data, 32'hDEAD_BEEF);
    chk("sw_w_strb", 32'(dn_if.w_strb), 32'hF);
    chk1("sw_up0_aw_ready", up0_if.aw_ready, 1'b1);
    chk1("sw_up1_quiet_fwd", up1_any(), 1'b0);
    tick();
    up0_if.aw_valid = 0; up0_if.w_valid = 0; up0_if.b_ready = 1;
    dn_if.b_valid = 1; dn_if.b_resp = RESP_OKAY;
    settle();
    chk("sw_state_resp", 32'(wr_state), 32'(WR_RESP));
    chk1("sw_up0_b_valid", up0_if.b_valid, 1'b1);
    chk("sw_up0_b_resp", 32'(up0_if.b_resp), 32'h0);
    chk1("sw_dn_b_ready", dn_if.b_ready, 1'b1);
    chk1("sw_up1_quiet_resp", up1_any(), 1'b0);
    tick();
    dn_if.b_valid = 0; up0_if.b_ready = 0;
    settle();
    chk("sw_state_idle", 32'(wr_state), 32'(WR_IDLE));

    // simultaneous reads: up0 first, then up1
    up0_if.ar_addr = 32'h20; up0_if.ar_valid = 1; up0_if.r_ready = 1;
    up1_if.ar_addr = 32'h30; up1_if.ar_valid = 1; up1_if.r_ready = 1;
    dn_if.ar_ready = 1;
    tick();
    chk1("rd0_ar_valid", dn_if.ar_valid, 1'b1);
    chk("rd0_ar_addr", dn_if.ar_addr, 32'h20);
    chk1("rd0_up0_ar_ready", up0_if.ar_ready, 1'b1);
    chk1("rd0_up1_ar_ready", up1_if.ar_ready, 1'b0);
    tick();
    up0_if.ar_valid = 0;
    dn_if.r_valid = 1; dn_if.r_data = 32'h1111_1111; dn_if.r_resp = RESP_OKAY;
    settle();
    chk1("rd0_up0_r_valid", up0_if.r_valid, 1'b1);
    chk("rd0_up0_r_data", up0_if.r_data, 32'h1111_1111);
    chk1("rd0_up1_r_valid", up1_if.r_valid, 1'b0);
    chk("rd0_up1_r_data", up1_if.r_data, 32'h0);
    tick();
    dn_if.r_valid = 0;
    tick();
    chk("rd1_ar_addr", dn_if.ar_addr, 32'h30);
    chk1("rd1_up1_ar_ready", up1_if.ar_ready, 1'b1);
    chk1("rd1_up0_ar_ready", up0_if.ar_ready, 1'b0);
    tick();
    up1_if.ar_valid = 0;
    dn_if.r_valid = 1; dn_if.r_data = 32'h2222_2222; dn_if.r_resp = RESP_SLVERR;
    settle();
    chk("rd1_up1_r_data", up1_if.r_data, 32'h2222_2222);
    chk("rd1_up1_r_resp", 32'(up1_if.r_resp), 32'h2);
    chk1("rd1_up0_r_valid", up0_if.r_valid, 1'b0);
    chk("rd1_up0_r_data", up0_if.r_data, 32'h0);
    tick();
    dn_if.r_valid = 0; dn_if.r_resp = RESP_OKAY;
    up0_if.r_ready = 0; up1_if.r_ready = 0;
    settle();
    chk("rd_state_idle", 32'(rd_state), 32'(RD_IDLE));

    // up1: W two cycles before AW, dn holds aw_ready low three cycles
    up1_if.w_data = 32'hCAFE_F00D; up1_if.w_strb = 4'h3; up1_if.w_valid = 1; up1_if.b_ready = 1;
    dn_if.aw_ready = 0; dn_if.w_ready = 1;
    settle();
    chk1("wfirst_no_w_ready", up1_if.w_ready, 1'b0);
    tick(); tick();
    chk("wfirst_still_idle", 32'(wr_state), 32'(WR_IDLE));
    up1_if.aw_addr = 32'h44; up1_if.aw_valid = 1;
    tick();
    chk1("wfirst_dn_w_valid", dn_if.w_valid, 1'b1);
    chk("wfirst_dn_w_data", dn_if.w_data, 32'hCAFE_F00D);
    chk1("wfirst_up1_w_ready", up1_if.w_ready, 1'b1);
    chk1("wfirst_up1_aw_ready", up1_if.aw_ready, 1'b0);
    tick();
    chk1("wfirst_w_masked", dn_if.w_valid, 1'b0);
    chk("wfirst_fwd_after_w", 32'(wr_state), 32'(WR_FWD));
    tick();
    chk("wfirst_fwd_wait_aw", 32'(wr_state), 32'(WR_FWD));
    dn_if.aw_ready = 1;
    settle();
    chk1("wfirst_up1_aw_ready_now", up1_if.aw_ready, 1'b1);
    tick();
    up1_if.aw_valid = 0; up1_if.w_valid = 0;
    dn_if.b_valid = 1; dn_if.b_resp = RESP_OKAY;
    settle();
    chk("wfirst_state_resp", 32'(wr_state), 32'(WR_RESP));
    chk1("wfirst_up1_b_valid", up1_if.b_valid, 1'b1);
    chk1("wfirst_up0_b_valid", up0_if.b_valid, 1'b0);
    tick();
    dn_if.b_valid = 0; up1_if.b_ready = 0;

    // concurrent: up0 writes, up1 reads
    up0_if.aw_addr = 32'h50; up0_if.aw_valid = 1; up0_if.w_data = 32'h1234_5678;
    up0_if.w_strb = 4'hF; up0_if.w_valid = 1; up0_if.b_ready = 1;
    up1_if.ar_addr = 32'h60; up1_if.ar_valid = 1; up1_if.r_ready = 1;
    dn_if.aw_ready = 1; dn_if.w_ready = 1; dn_if.ar_ready = 1;
    tick();
    chk1("conc_aw_and_ar", dn_if.aw_valid & dn_if.ar_valid, 1'b1);
    chk("conc_aw_addr", dn_if.aw_addr, 32'h50);
    chk("conc_ar_addr", dn_if.ar_addr, 32'h60);
    chk1("conc_up1_ar_ready", up1_if.ar_ready, 1'b1);
    tick();
    up0_if.aw_valid = 0; up0_if.w_valid = 0; up1_if.ar_valid = 0;
    dn_if.b_valid = 1; dn_if.b_resp = RESP_SLVERR;
    dn_if.r_valid = 1; dn_if.r_data = 32'hA5A5_A5A5; dn_if.r_resp = RESP_OKAY;
    settle();
    chk1("conc_up0_b_valid", up0_if.b_valid, 1'b1);
    chk("conc_up0_b_resp", 32'(up0_if.b_resp), 32'h2);
    chk1("conc_up1_r_valid", up1_if.r_valid, 1'b1);
    chk("conc_up1_r_data", up1_if.r_data, 32'hA5A5_A5A5);
    chk1("conc_up0_r_valid", up0_if.r_valid, 1'b0);
    chk1("conc_up1_b_valid", up1_if.b_valid, 1'b0);
    tick();
    dn_if.b_valid = 0; dn_if.r_valid = 0; dn_if.b_resp = RESP_OKAY;
    up0_if.b_ready = 0; up1_if.r_ready = 0;
    settle();
    chk("conc_wr_idle", 32'(wr_state), 32'(WR_IDLE));
    chk("conc_rd_idle", 32'(rd_state), 32'(RD_IDLE));

    // reset while up1's B is pending; last winner was up0, so only reset makes up0 win the tie
    up1_if.aw_addr = 32'h70; up1_if.aw_valid = 1; up1_if.w_data = 32'h7; up1_if.w_valid = 1;
    up1_if.w_strb = 4'hF;
    tick(); tick();
    up1_if.aw_valid = 0; up1_if.w_valid = 0;
    dn_if.b_valid = 1;
    settle();
    chk("mrst_in_resp", 32'(wr_state), 32'(WR_RESP));
    chk1("mrst_b_pending", up1_if.b_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk1("mrst_outs_zero", any_out(), 1'b0);
    chk("mrst_aw_addr_zero", dn_if.aw_addr, 32'h0);
    chk("mrst_state_idle", 32'(wr_state), 32'(WR_IDLE));
    dn_if.b_valid = 0;
    up0_if.aw_addr = 32'h80; up0_if.aw_valid = 1;
    up1_if.aw_addr = 32'h90; up1_if.aw_valid = 1;
    tick();
    chk1("mrst_tie_up0", up0_if.aw_ready, 1'b1);
    chk1("mrst_tie_not_up1", up1_if.aw_ready, 1'b0);
    chk("mrst_tie_addr", dn_if.aw_addr, 32'h80);
    rst = 1'b1;
    up0_if.aw_valid = 0; up1_if.aw_valid = 0;
    tick(); tick();
    rst = 1'b0;

    // fairness: six back-to-back writes from each master must alternate 0,1,0,1...
    cnt[0] = 0; cnt[1] = 0;
    up0_if.b_ready = 1; up1_if.b_ready = 1;
    dn_if.aw_ready = 1; dn_if.w_ready = 1; dn_if.b_resp = RESP_OKAY;
    load_wr(0, 0); load_wr(1, 0);
    for (int k = 0; k < 12; k++) begin
      g = k % 2;
      tick();
      chk1($sformatf("fair%0d_gnt", k), g == 0 ? up0_if.aw_ready : up1_if.aw_ready, 1'b1);
      chk1($sformatf("fair%0d_other", k), g == 0 ? up1_if.aw_ready : up0_if.aw_ready, 1'b0);
      chk($sformatf("fair%0d_addr", k), dn_if.aw_addr,
          (g == 0 ? 32'h100 : 32'h200) + 32'(4 * cnt[g]));
      tick();
      cnt[g]++;
      load_wr(g, cnt[g]);
      dn_if.b_valid = 1;
      settle();
      chk1($sformatf("fair%0d_b", k), g == 0 ? up0_if.b_valid : up1_if.b_valid, 1'b1);
      tick();
      dn_if.b_valid = 0;
    end
    settle();
    chk("fair_done_idle", 32'(wr_state), 32'(WR_IDLE));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
